// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the MIPS core together with the combinational
// front end of the EX stage. Decoded operands and control bits from ID are
// captured on the rising clock edge. The EX-side outputs then apply operand
// forwarding, the ALUSrc immediate select and the ALU-control decode with no
// further register stage. The block also detects load-use hazards and
// handles stall, flush and bubble insertion.
//
// Configuration macro: EX_FORWARDING_EN
//   defined   - EX/MEM and MEM/WB results are forwarded to operand1,
//               operand2 and store_data. load_use_stall fires only for a
//               load in EX.
//   undefined - the exmem_* and memwb_* inputs are ignored and operands come
//               from registered data only. load_use_stall fires for any valid
//               register-writing instruction in EX whose destination is read
//               by ID. MEM/WB distance hazards must be covered by software.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold stage / replace next contents with a bubble
//   id_*                  decoded instruction fields and control from ID
//   exmem_*, memwb_*      writeback candidates used for forwarding
//   operand1, operand2    ALU operands
//   alu_control           4-bit ALU operation select
//   store_data            forwarded rt value for stores
//   ex_dest               destination register (rd if reg_dst, else rt)
//   ex_reg_write, ex_mem_read, ex_mem_write
//                         control outputs, qualified by ex_valid
//   ex_valid              stage holds a real instruction
//   illegal_funct         valid R-type instruction with unsupported funct
//   load_use_stall        request to freeze PC/IF/ID for one cycle
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm16,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [5:0]        id_funct,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_zero_ext,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_dst,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic              illegal_funct,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [5:0]        funct;
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              reg_dst;
    } ex_fields_t;

    ex_fields_t        ex_q;
    ex_fields_t        ex_d;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // The immediate is extended before it is registered so EX sees a ready
    // DATA_W value and the extension stays off the forwarding path.
    assign imm_ext = id_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm16}
                                 : {{(DATA_W-16){id_imm16[15]}}, id_imm16};

    // A bubble clears every field, not only the control bits, so an empty
    // stage presents zero operands and never matches a forwarding source.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = imm_ext;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd        = id_rd;
            ex_d.funct     = id_funct;
            ex_d.alu_op    = id_alu_op;
            ex_d.alu_src   = id_alu_src;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
            ex_d.reg_dst   = id_reg_dst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef EX_FORWARDING_EN
    // EX/MEM is the younger result and therefore wins over MEM/WB.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs)) begin
            fwd_rs = memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rt)) begin
            fwd_rt = memwb_result;
        end
    end

    // A load's data arrives one stage too late to forward into EX.
    assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                            ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd, exmem_result,
                                 memwb_reg_write, memwb_rd, memwb_result};

    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;

    // Without forwarding, any result still in EX is unavailable to ID.
    assign load_use_stall = ex_reg_write && (ex_dest != '0) &&
                            ((ex_dest == id_rs) || (ex_dest == id_rt));
`endif

    assign operand1     = fwd_rs;
    assign operand2     = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign store_data   = fwd_rt;
    assign ex_dest      = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read  = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write = ex_q.valid & ex_q.mem_write;

    // An empty stage decodes as add so the ALU never sees the illegal code.
    always_comb begin
        alu_control   = 4'b0010;
        illegal_funct = 1'b0;
        if (ex_q.valid) begin
            case (ex_q.alu_op)
                2'b00:   alu_control = 4'b0010;
                2'b01:   alu_control = 4'b0110;
                2'b11:   alu_control = 4'b0001;
                default: begin
                    case (ex_q.funct)
                        6'b100000: alu_control = 4'b0010;
                        6'b100010: alu_control = 4'b0110;
                        6'b100100: alu_control = 4'b0000;
                        6'b100101: alu_control = 4'b0001;
                        6'b101010: alu_control = 4'b0111;
                        6'b100111: alu_control = 4'b1100;
                        default: begin
                            alu_control   = 4'b1111;
                            illegal_funct = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A table of directed instruction
// vectors covers the decode, immediate and operand paths; hand-written
// sequences cover reset, forwarding, load-use bubbles, stall and flush.
// Expectations follow EX_FORWARDING_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, idValid;
    logic [31:0] idRsData, idRtData;
    logic [15:0] idImm16;
    logic [4:0]  idRs, idRt, idRd;
    logic [5:0]  idFunct;
    logic [1:0]  idAluOp;
    logic        idAluSrc, idZeroExt, idRegWrite, idMemRead, idMemWrite, idRegDst;
    logic        exmemRegWrite, memwbRegWrite;
    logic [4:0]  exmemRd, memwbRd;
    logic [31:0] exmemResult, memwbResult;
    logic [31:0] operand1, operand2, storeData;
    logic [3:0]  aluControl;
    logic [4:0]  exDest;
    logic        exRegWrite, exMemRead, exMemWrite, exValid, illegalFunct, loadUseStall;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(idValid), .id_rs_data(idRsData), .id_rt_data(idRtData),
        .id_imm16(idImm16), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
        .id_funct(idFunct), .id_alu_op(idAluOp), .id_alu_src(idAluSrc),
        .id_zero_ext(idZeroExt), .id_reg_write(idRegWrite),
        .id_mem_read(idMemRead), .id_mem_write(idMemWrite), .id_reg_dst(idRegDst),
        .exmem_reg_write(exmemRegWrite), .exmem_rd(exmemRd), .exmem_result(exmemResult),
        .memwb_reg_write(memwbRegWrite), .memwb_rd(memwbRd), .memwb_result(memwbResult),
        .operand1(operand1), .operand2(operand2), .alu_control(aluControl),
        .store_data(storeData), .ex_dest(exDest), .ex_reg_write(exRegWrite),
        .ex_mem_read(exMemRead), .ex_mem_write(exMemWrite), .ex_valid(exValid),
        .illegal_funct(illegalFunct), .load_use_stall(loadUseStall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic        zeroExt;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        regDst;
        logic [31:0] expOp1;
        logic [31:0] expOp2;
        logic [3:0]  expCtl;
        logic [31:0] expStore;
        logic [4:0]  expDest;
        logic        expIllegal;
    } vec_t;

    vec_t vecs[12];
    vec_t tmp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        idValid    = 1'b1;
        idRsData   = v.rsData;
        idRtData   = v.rtData;
        idImm16    = v.imm;
        idRs       = v.rs;
        idRt       = v.rt;
        idRd       = v.rd;
        idFunct    = v.funct;
        idAluOp    = v.aluOp;
        idAluSrc   = v.aluSrc;
        idZeroExt  = v.zeroExt;
        idRegWrite = v.regWrite;
        idMemRead  = v.memRead;
        idMemWrite = v.memWrite;
        idRegDst   = v.regDst;
    endtask

    task automatic idleInputs();
        idValid = 1'b0; idRsData = '0; idRtData = '0; idImm16 = '0;
        idRs = '0; idRt = '0; idRd = '0; idFunct = '0; idAluOp = '0;
        idAluSrc = 1'b0; idZeroExt = 1'b0; idRegWrite = 1'b0;
        idMemRead = 1'b0; idMemWrite = 1'b0; idRegDst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //           rsData        rtData        imm       rs  rt  rd  funct       op    src ze rw mr mw rd   op1           op2           ctl      store         dst ill
        vecs[0]  = '{32'h0000F0F0, 32'h00000FF0, 16'h0000, 1,  2,  3,  6'b100100, 2'b10, 0, 0, 1, 0, 0, 1, 32'h0000F0F0, 32'h00000FF0, 4'b0000, 32'h00000FF0, 3,  0};
        vecs[1]  = '{32'h00000010, 32'h00000055, 16'hFFFC, 1,  4,  7,  6'b000000, 2'b00, 1, 0, 1, 0, 0, 0, 32'h00000010, 32'hFFFFFFFC, 4'b0010, 32'h00000055, 4,  0};
        vecs[2]  = '{32'h00000010, 32'h00000055, 16'hFFFC, 1,  4,  7,  6'b000000, 2'b11, 1, 1, 1, 0, 0, 0, 32'h00000010, 32'h0000FFFC, 4'b0001, 32'h00000055, 4,  0};
        vecs[3]  = '{32'h00000007, 32'h00000009, 16'h0004, 2,  3,  0,  6'b000000, 2'b01, 0, 0, 0, 0, 0, 0, 32'h00000007, 32'h00000009, 4'b0110, 32'h00000009, 3,  0};
        vecs[4]  = '{32'h00000100, 32'h00000200, 16'h0000, 5,  6,  8,  6'b100000, 2'b10, 0, 0, 1, 0, 0, 1, 32'h00000100, 32'h00000200, 4'b0010, 32'h00000200, 8,  0};
        vecs[5]  = '{32'h00000300, 32'h00000001, 16'h0000, 7,  8,  9,  6'b100010, 2'b10, 0, 0, 1, 0, 0, 1, 32'h00000300, 32'h00000001, 4'b0110, 32'h00000001, 9,  0};
        vecs[6]  = '{32'h0000000A, 32'h00000005, 16'h0000, 10, 11, 12, 6'b100101, 2'b10, 0, 0, 1, 0, 0, 1, 32'h0000000A, 32'h00000005, 4'b0001, 32'h00000005, 12, 0};
        vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, 16'h0000, 13, 14, 15, 6'b101010, 2'b10, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 15, 0};
        vecs[8]  = '{32'h00000001, 32'h00000002, 16'h0000, 16, 17, 18, 6'b100111, 2'b10, 0, 0, 1, 0, 0, 1, 32'h00000001, 32'h00000002, 4'b1100, 32'h00000002, 18, 0};
        vecs[9]  = '{32'h00000003, 32'h00000004, 16'h0000, 19, 20, 21, 6'b000000, 2'b10, 0, 0, 1, 0, 0, 1, 32'h00000003, 32'h00000004, 4'b1111, 32'h00000004, 21, 1};
        vecs[10] = '{32'h00001000, 32'hDEADBEEF, 16'h0008, 22, 23, 0,  6'b000000, 2'b00, 1, 0, 0, 0, 1, 0, 32'h00001000, 32'h00000008, 4'b0010, 32'hDEADBEEF, 23, 0};
        vecs[11] = '{32'h00002000, 32'h00000000, 16'h8000, 24, 25, 0,  6'b000000, 2'b00, 1, 0, 1, 1, 0, 0, 32'h00002000, 32'hFFFF8000, 4'b0010, 32'h00000000, 25, 0};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        exmemRegWrite = 1'b0; exmemRd = '0; exmemResult = '0;
        memwbRegWrite = 1'b0; memwbRd = '0; memwbResult = '0;
        idleInputs();
        #2;
        checkOutput("rst.valid", exValid, 0);
        checkOutput("rst.op1", operand1, 0);
        checkOutput("rst.op2", operand2, 0);
        checkOutput("rst.ctl", aluControl, 4'b0010);
        checkOutput("rst.store", storeData, 0);
        checkOutput("rst.dest", exDest, 0);
        checkOutput("rst.ctrl", {exRegWrite, exMemRead, exMemWrite, illegalFunct, loadUseStall}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Table: each vector is loaded into an empty stage, then cleared.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d.op1", i), operand1, vecs[i].expOp1);
            checkOutput($sformatf("v%0d.op2", i), operand2, vecs[i].expOp2);
            checkOutput($sformatf("v%0d.ctl", i), aluControl, vecs[i].expCtl);
            checkOutput($sformatf("v%0d.store", i), storeData, vecs[i].expStore);
            checkOutput($sformatf("v%0d.dest", i), exDest, vecs[i].expDest);
            checkOutput($sformatf("v%0d.illegal", i), illegalFunct, vecs[i].expIllegal);
            checkOutput($sformatf("v%0d.valid", i), exValid, 1);
            checkOutput($sformatf("v%0d.rw", i), exRegWrite, vecs[i].regWrite);
            checkOutput($sformatf("v%0d.mr", i), exMemRead, vecs[i].memRead);
            checkOutput($sformatf("v%0d.mw", i), exMemWrite, vecs[i].memWrite);
            idleInputs();
            tick();
            checkOutput($sformatf("v%0d.cleared", i), exValid, 0);
        end

        // Reset asserted between edges clears the stage immediately.
        applyStimulus(vecs[0]);
        tick();
        checkOutput("rstmid.loaded", exValid, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstmid.valid", exValid, 0);
        checkOutput("rstmid.op1", operand1, 0);
        checkOutput("rstmid.op2", operand2, 0);
        checkOutput("rstmid.ctl", aluControl, 4'b0010);
        @(negedge clk);
        reset = 1'b0;
        idleInputs();
        tick();

        // Forwarding priority on rs, then rt.
        tmp = vecs[3];
        tmp.rs = 3; tmp.rt = 6; tmp.rsData = 32'h99; tmp.rtData = 32'h66;
        tmp.aluOp = 2'b00;
        applyStimulus(tmp);
        tick();
        idleInputs();
        exmemRegWrite = 1'b1; exmemRd = 3; exmemResult = 32'h11;
        memwbRegWrite = 1'b1; memwbRd = 3; memwbResult = 32'h22;
        #1 checkOutput("fwd.exmem", operand1, FWD ? 32'h11 : 32'h99);
        exmemRegWrite = 1'b0;
        #1 checkOutput("fwd.memwb", operand1, FWD ? 32'h22 : 32'h99);
        exmemRegWrite = 1'b1; exmemRd = 0; memwbRd = 0;
        #1 checkOutput("fwd.reg0", operand1, 32'h99);
        memwbRd = 6; memwbResult = 32'h33;
        #1;
        checkOutput("fwd.rt.op2", operand2, FWD ? 32'h33 : 32'h66);
        checkOutput("fwd.rt.store", storeData, FWD ? 32'h33 : 32'h66);
        exmemRegWrite = 1'b0; memwbRegWrite = 1'b0; exmemRd = '0; memwbRd = '0;
        tick();

        // Load-use: lw writing r5 in EX, consumer of r5 in ID.
        tmp = vecs[11];
        tmp.rs = 1; tmp.rt = 5;
        applyStimulus(tmp);
        tick();
        tmp = vecs[4];
        tmp.rs = 2; tmp.rt = 5; tmp.rd = 9; tmp.rsData = 32'h77; tmp.rtData = 32'h88;
        applyStimulus(tmp);
        #1 checkOutput("lu.rt", loadUseStall, 1);
        idRs = 5; idRt = 2;
        #1 checkOutput("lu.rs", loadUseStall, 1);
        tick();
        checkOutput("lu.bubble", exValid, 0);
        checkOutput("lu.cleared", loadUseStall, 0);
        tick();
        checkOutput("lu.load.valid", exValid, 1);
        checkOutput("lu.load.op1", operand1, 32'h77);
        checkOutput("lu.load.dest", exDest, 9);
        idleInputs();
        tick();

        // Load to r0 never stalls.
        tmp = vecs[11];
        tmp.rs = 1; tmp.rt = 0;
        applyStimulus(tmp);
        tick();
        idleInputs();
        idValid = 1'b1;
        #1 checkOutput("lu.r0", loadUseStall, 0);
        idleInputs();
        tick();

        // ALU result in EX: stalls only when forwarding is absent.
        tmp = vecs[4];
        tmp.rd = 5;
        applyStimulus(tmp);
        tick();
        idleInputs();
        idValid = 1'b1; idRs = 5;
        #1 checkOutput("lu.alu", loadUseStall, FWD ? 1'b0 : 1'b1);
        idleInputs();
        tick();

        // Stall holds for three cycles, then stall+flush produces a bubble.
        applyStimulus(vecs[4]);
        tick();
        stall = 1'b1;
        applyStimulus(vecs[0]);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("stall%0d.valid", c), exValid, 1);
            checkOutput($sformatf("stall%0d.op1", c), operand1, 32'h100);
            checkOutput($sformatf("stall%0d.ctl", c), aluControl, 4'b0010);
            checkOutput($sformatf("stall%0d.dest", c), exDest, 8);
        end
        flush = 1'b1;
        tick();
        checkOutput("stallflush.valid", exValid, 0);
        checkOutput("stallflush.rw", exRegWrite, 0);
        stall = 1'b0; flush = 1'b0;
        tick();
        checkOutput("resume.op1", operand1, 32'h0000F0F0);
        checkOutput("resume.ctl", aluControl, 4'b0000);

        // Flush alone replaces the next contents with a bubble.
        applyStimulus(vecs[10]);
        flush = 1'b1;
        tick();
        checkOutput("flush.valid", exValid, 0);
        checkOutput("flush.mw", exMemWrite, 0);
        checkOutput("flush.ctl", aluControl, 4'b0010);
        flush = 1'b0;
        idleInputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
